// File: rtl/apb4_regbank_if.sv
// APB4 completer-side bus bundle for apb4_regbank.
// The master modport drives requests; the slave modport returns PRDATA/PREADY/PSLVERR.
interface apb4_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_regbank.sv
// Parametrised APB4 register bank: byte strobes, fixed wait states, hardware-sourced
// read-only registers, PSLVERR on bad accesses and per-register write-commit pulses.
module apb4_regbank #(
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  apb4_regbank_if.slave                  apb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int         IDX_W     = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam int         NUM_SLOTS = 1 << IDX_W;
  localparam int         STRB_W    = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [3:0]                           cnt_q, cnt_d;
  logic [NUM_REGS-1:0]                  wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]                     idx;
  logic                                 upper_set;
  logic                                 acc_err;
  logic                                 commit;
  logic [NUM_SLOTS-1:0]                 slot_valid;
  logic [NUM_SLOTS-1:0]                 slot_ro;
  logic [NUM_SLOTS-1:0]                 commit_onehot;
  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] rd_word;

  // Address decode; slots past NUM_REGS exist only so idx can index every table safely.
  assign idx       = apb.PADDR[IDX_W+1:2];
  assign upper_set = (apb.PADDR >> (IDX_W + 2)) != '0;
  assign acc_err   = (apb.PADDR[1:0] != 2'b00) || upper_set || !slot_valid[idx] ||
                     (apb.PWRITE && slot_ro[idx]);

  assign commit        = (state_q == S_DONE) && apb.PSEL && apb.PWRITE && !acc_err && (|apb.PSTRB);
  assign commit_onehot = commit ? (NUM_SLOTS'(1) << idx) : '0;
  assign wr_pulse_d    = commit_onehot[NUM_REGS-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < NUM_REGS) begin : g_reg
        assign slot_valid[gi] = 1'b1;
        assign slot_ro[gi]    = RO_MASK[gi];
        if (RO_MASK[gi]) begin : g_ro
          assign rd_word[gi]                             = hw_in[gi*DATA_WIDTH +: DATA_WIDTH];
          assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
          logic [DATA_WIDTH-1:0] data_q, data_d;

          always_comb begin
            data_d = data_q;
            if (wr_pulse_d[gi]) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (apb.PSTRB[b]) data_d[8*b +: 8] = apb.PWDATA[8*b +: 8];
              end
            end
          end

          always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) data_q <= '0;
            else          data_q <= data_d;
          end

          assign rd_word[gi]                             = data_q;
          assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = data_q;
        end
      end else begin : g_pad
        assign slot_valid[gi] = 1'b0;
        assign slot_ro[gi]    = 1'b0;
        assign rd_word[gi]    = '0;
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Dropping PSEL mid-wait abandons the transfer without any side effect.
        if (!apb.PSEL)          state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_DONE;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign apb.PREADY  = (state_q == S_DONE);
  assign apb.PSLVERR = (state_q == S_DONE) && acc_err;
  assign apb.PRDATA  = ((state_q == S_DONE) && !acc_err && !apb.PWRITE) ? rd_word[idx] : '0;
  assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_apb4_regbank.sv
// Scoreboard bench for apb4_regbank: three instances (0, 3 and 2 wait states) share
// one APB driver; a negedge monitor pops the expected response on every PREADY.
module tb_apb4_regbank;

  logic PCLK;
  logic PRESETn;

  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [255:0]      hw_vec;

  logic [2:0]        pready;
  logic [2:0]        pslverr;
  logic [2:0][31:0]  prdata;
  logic [2:0][255:0] rout;
  logic [2:0][7:0]   wrp;

  typedef struct {
    int          dut;
    logic        is_rd;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int         WC = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
      localparam logic [7:0] RO = (gi == 0) ? 8'h08 : 8'h00;

      apb4_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

      assign bus.PSEL    = psel[gi];
      assign bus.PENABLE = penable;
      assign bus.PWRITE  = pwrite;
      assign bus.PADDR   = paddr;
      assign bus.PWDATA  = pwdata;
      assign bus.PSTRB   = pstrb;
      assign pready[gi]  = bus.PREADY;
      assign pslverr[gi] = bus.PSLVERR;
      assign prdata[gi]  = bus.PRDATA;

      apb4_regbank #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(WC), .RO_MASK(RO)
      ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .apb      (bus.slave),
        .hw_in    (hw_vec),
        .reg_out  (rout[gi]),
        .wr_pulse (wrp[gi])
      );
    end
  endgenerate

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every PREADY pulse consumes exactly one expected response.
  always @(negedge PCLK) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (pready[d]) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_pready", 32'(d), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk(e.dut == d, {e.name, "_dut"}, 32'(d), 32'(e.dut));
          chk(pslverr[d] == e.err, {e.name, "_pslverr"}, 32'(pslverr[d]), 32'(e.err));
          if (e.is_rd) chk(prdata[d] == e.rdata, {e.name, "_prdata"}, prdata[d], e.rdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Starts at posedge+1 and returns at posedge+1 after the DONE cycle, so calls chain back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input bit exp_err,
                      input int exp_wait, input logic [7:0] exp_pulse, input string name);
    exp_t e;
    int   waits;
    bit   done;
    e.dut = d; e.is_rd = !wr; e.rdata = exp_rd; e.err = exp_err; e.name = name;
    sb_q.push_back(e);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge PCLK);
    #1 penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done && waits < 40) begin
      @(negedge PCLK);
      if (pready[d]) done = 1'b1;
      else           waits++;
    end
    chk(done && (waits == exp_wait), {name, "_wait"}, 32'(waits), 32'(exp_wait));
    @(posedge PCLK);
    #1;
    psel    = '0;
    penable = 1'b0;
    chk(wrp[d] == exp_pulse, {name, "_wr_pulse"}, 32'(wrp[d]), 32'(exp_pulse));
    $display("xfer %-12s dut%0d %s addr=0x%02h wdata=0x%08h strb=%h wait=%0d pulse=%02h",
             name, d, wr ? "WR" : "RD", addr, wdata, strb, waits, wrp[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int pulse_seen;
    for (int i = 0; i < 8; i++) hw_vec[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
    hw_vec[96 +: 32] = 32'hCAFE_0001;
    PRESETn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk(pready == 3'b000, "rst_pready", 32'(pready), 32'h0);
    chk(pslverr == 3'b000, "rst_pslverr", 32'(pslverr), 32'h0);
    chk(prdata[0] == 32'h0, "rst_prdata", prdata[0], 32'h0);
    chk(wrp[0] == 8'h00, "rst_wr_pulse", 32'(wrp[0]), 32'h0);
    chk(rout[0] == '0, "rst_reg_out", rout[0][31:0], 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    xfer(0, 1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 8'h02, "wr_r1");
    chk(rout[0][63:32] == 32'hDEAD_BEEF, "reg_out_r1", rout[0][63:32], 32'hDEAD_BEEF);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 8'h00, "rd_r1");
    idle(1);
    xfer(0, 1, 8'h08, 32'h1122_3344, 4'hF, 32'h0, 0, 0, 8'h04, "wr_r2");
    xfer(0, 1, 8'h08, 32'hAABB_CCDD, 4'h5, 32'h0, 0, 0, 8'h04, "wr_r2_strb");
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 32'h11BB_33DD, 0, 0, 8'h00, "rd_r2");
    xfer(0, 0, 8'h20, 32'h0, 4'h0, 32'h0, 1, 0, 8'h00, "rd_oob");
    xfer(0, 0, 8'h02, 32'h0, 4'h0, 32'h0, 1, 0, 8'h00, "rd_misal");
    xfer(0, 1, 8'h0C, 32'h1234_5678, 4'hF, 32'h0, 1, 0, 8'h00, "wr_ro");
    chk(rout[0][127:96] == 32'h0, "reg_out_ro", rout[0][127:96], 32'h0);
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 32'hCAFE_0001, 0, 0, 8'h00, "rd_ro");
    xfer(0, 1, 8'h40, 32'h7777_7777, 4'hF, 32'h0, 1, 0, 8'h00, "wr_upper");
    xfer(0, 1, 8'h04, 32'h0, 4'h0, 32'h0, 0, 0, 8'h00, "wr_nostrb");
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 8'h00, "rd_r1_again");
    xfer(0, 0, 8'h00, 32'h0, 4'h0, 32'h0, 0, 0, 8'h00, "rd_r0_clean");
    idle(1);

    c0 = cyc;
    xfer(0, 1, 8'h00, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 0, 8'h01, "b2b_wr");
    xfer(0, 0, 8'h00, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 0, 8'h00, "b2b_rd");
    chk((cyc - c0) == 4, "b2b_cycles", 32'(cyc - c0), 32'd4);
    idle(1);

    c0 = cyc;
    xfer(1, 0, 8'h00, 32'h0, 4'h0, 32'h0, 0, 3, 8'h00, "rd_wait3");
    chk((cyc - c0) == 5, "wait3_cycles", 32'(cyc - c0), 32'd5);
    xfer(1, 1, 8'h1C, 32'h0000_00A5, 4'h1, 32'h0, 0, 3, 8'h80, "wr_wait3");
    xfer(1, 0, 8'h1C, 32'h0, 4'h0, 32'h0000_00A5, 0, 3, 8'h00, "rd_wait3_r7");
    idle(1);

    xfer(2, 1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 2, 8'h01, "wr_pre_rst");
    chk(rout[2][31:0] == 32'hFFFF_FFFF, "reg_out_pre_rst", rout[2][31:0], 32'hFFFF_FFFF);
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h04;
    pwdata  = 32'h1234_5678;
    pstrb   = 4'hF;
    @(posedge PCLK);
    #1 penable = 1'b1;
    @(negedge PCLK);
    chk(pready[2] == 1'b0, "abort_in_wait", 32'(pready[2]), 32'h0);
    PRESETn = 1'b0;
    #1;
    chk(pready[2] == 1'b0, "rst_mid_pready", 32'(pready[2]), 32'h0);
    chk(rout[2] == '0, "rst_mid_regs", rout[2][31:0], 32'h0);
    pulse_seen = 0;
    repeat (2) begin
      @(negedge PCLK);
      if (wrp[2] != 8'h00 || pready[2]) pulse_seen++;
    end
    psel    = '0;
    penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      if (wrp[2] != 8'h00 || pready[2]) pulse_seen++;
    end
    chk(pulse_seen == 0, "rst_no_side_effect", 32'(pulse_seen), 32'h0);
    @(posedge PCLK);
    #1;
    xfer(2, 0, 8'h00, 32'h0, 4'h0, 32'h0, 0, 2, 8'h00, "rd_post_rst");
    xfer(2, 1, 8'h04, 32'h0000_0055, 4'hF, 32'h0, 0, 2, 8'h02, "wr_post_rst");
    xfer(2, 0, 8'h04, 32'h0, 4'h0, 32'h0000_0055, 0, 2, 8'h00, "rd_post_rst_r1");

    idle(3);
    chk(sb_q.size() == 0, "scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
